// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// FSM state encoding, access sizes and lane-shift helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic state_t;
  localparam state_t IDLE   = 1'b0;
  localparam state_t RMW_WR = 1'b1;

  typedef logic [1:0] size_t;
  localparam size_t SZ_B = 2'd0;
  localparam size_t SZ_H = 2'd1;
  localparam size_t SZ_W = 2'd2;

  localparam int LANE_W = 2;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  // Unknown load encodings behave as LW.
  function automatic size_t load_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: load_size = SZ_B;
      F3_H, F3_HU: load_size = SZ_H;
      default:     load_size = SZ_W;
    endcase
  endfunction

  // Only SB and SH are sub-word; every other store encoding is a full word.
  function automatic size_t store_size(input logic [2:0] f3);
    case (f3)
      F3_B:    store_size = SZ_B;
      F3_H:    store_size = SZ_H;
      default: store_size = SZ_W;
    endcase
  endfunction

  // Halfwords look only at lane[1]; words are always lane 0.
  function automatic logic [4:0] lane_shift(input size_t size, input logic [LANE_W-1:0] lane);
    case (size)
      SZ_B:    lane_shift = {lane, 3'b000};
      SZ_H:    lane_shift = {lane[1], 4'b0000};
      default: lane_shift = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational lane merge. EXTRACT=0 drops data into the selected lane of word;
// EXTRACT=1 mirrors it, dropping the selected lane of word into the low end of data.
module byte_lane_merge
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit EXTRACT = 1'b0
) (
  input  logic [XLEN-1:0]   word,
  input  logic [LANE_W-1:0] lane,
  input  size_t             size,
  input  logic [XLEN-1:0]   data,
  output logic [XLEN-1:0]   result
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] mask_low;
  logic [XLEN-1:0] mask;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mask_low = '1;
    case (size)
      SZ_B:    mask_low = {{(XLEN-BYTE_W){1'b0}}, {BYTE_W{1'b1}}};
      SZ_H:    mask_low = {{(XLEN-HALF_W){1'b0}}, {HALF_W{1'b1}}};
      default: mask_low = '1;
    endcase
  end

  assign shamt = lane_shift(size, lane);
  assign mask  = mask_low << shamt;

  generate
    if (EXTRACT) begin : g_extract
      assign result = (data & ~mask_low) | ((word >> shamt) & mask_low);
    end else begin : g_insert
      assign result = (word & ~mask) | ((data << shamt) & mask);
    end
  endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-only data memory; SB/SH run as a
// 2-cycle read-modify-write. Define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  store_data,
  input  logic [XLEN-1:0]  dmem_dout,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_din,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [XLEN-1:0]  load_data,
  output logic             stall,
  output logic             misaligned,
  output logic [CNT_W-1:0] rmw_count
);

  state_t            state;
  logic [XLEN-1:0]   lat_word;
  logic [XLEN-1:0]   lat_data;
  logic [XLEN-3:0]   lat_waddr;
  logic [LANE_W-1:0] lat_lane;
  size_t             lat_size;

  size_t           ld_size;
  size_t           st_size;
  size_t           acc_size;
  logic            mis_raw;
  logic            start_rmw;
  logic            ld_signed;
  logic [4:0]      sign_idx;
  logic [XLEN-1:0] sign_fill;
  logic [XLEN-1:0] ld_value;
  logic [XLEN-1:0] rmw_word;

  assign ld_size  = load_size(funct3);
  assign st_size  = store_size(funct3);
  assign acc_size = mem_read ? ld_size : st_size;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign mis_raw = (state == IDLE) && (mem_read || mem_write) &&
                   (((acc_size == SZ_H) && addr[0]) ||
                    ((acc_size == SZ_W) && (addr[1:0] != 2'b00)));
`else
  assign mis_raw = 1'b0;
`endif
  assign misaligned = mis_raw;

  // A load wins over a simultaneous store, so only a pure sub-word store opens an RMW.
  assign start_rmw = (state == IDLE) && !mem_read && mem_write &&
                     (st_size != SZ_W) && !mis_raw;

  assign ld_signed = (funct3 == F3_B) || (funct3 == F3_H);
  assign sign_idx  = lane_shift(ld_size, addr[1:0]) + ((ld_size == SZ_B) ? 5'd7 : 5'd15);
  assign sign_fill = (ld_signed && dmem_dout[sign_idx]) ? '1 : '0;

  byte_lane_merge #(.XLEN(XLEN), .EXTRACT(1'b1)) u_load_extract (
    .word   (dmem_dout),
    .lane   (addr[1:0]),
    .size   (ld_size),
    .data   (sign_fill),
    .result (ld_value)
  );

  byte_lane_merge #(.XLEN(XLEN), .EXTRACT(1'b0)) u_store_merge (
    .word   (lat_word),
    .lane   (lat_lane),
    .size   (lat_size),
    .data   (lat_data),
    .result (rmw_word)
  );

  // NOTE: sequential state uses non-blocking assignments only. The latched copy of the
  // memory word is an ordinary register and is cleared by reset like everything else.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lat_word  <= '0;
      lat_data  <= '0;
      lat_waddr <= '0;
      lat_lane  <= '0;
      lat_size  <= SZ_B;
      rmw_count <= '0;
    end else if (state == RMW_WR) begin
      state     <= IDLE;
      rmw_count <= rmw_count + CNT_W'(1);
    end else if (start_rmw) begin
      state     <= RMW_WR;
      lat_word  <= dmem_dout;
      lat_data  <= store_data;
      lat_waddr <= addr[XLEN-1:2];
      lat_lane  <= addr[1:0];
      lat_size  <= st_size;
    end
  end

  always_comb begin
    dmem_addr  = '0;
    dmem_din   = '0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    load_data  = '0;
    stall      = 1'b0;
    if (state == RMW_WR) begin
      dmem_write = 1'b1;
      dmem_addr  = {lat_waddr, 2'b00};
      dmem_din   = rmw_word;
    end else if (!mis_raw) begin
      if (mem_read) begin
        dmem_read = 1'b1;
        dmem_addr = {addr[XLEN-1:2], 2'b00};
        load_data = ld_value;
      end else if (mem_write) begin
        dmem_addr = {addr[XLEN-1:2], 2'b00};
        if (st_size == SZ_W) begin
          dmem_write = 1'b1;
          dmem_din   = store_data;
        end else begin
          dmem_read = 1'b1;
          stall     = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a word-only memory model and a
// byte-level reference memory; adapts to MEM_ACCESS_MISALIGN_TRAP_EN.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, dmem_dout;
  logic [31:0] dmem_addr, dmem_din, load_data;
  logic        dmem_read, dmem_write, stall, misaligned;
  logic [31:0] rmw_count;

  mem_access_unit #(.XLEN(32), .CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .dmem_dout  (dmem_dout),
    .dmem_addr  (dmem_addr),
    .dmem_din   (dmem_din),
    .dmem_read  (dmem_read),
    .dmem_write (dmem_write),
    .load_data  (load_data),
    .stall      (stall),
    .misaligned (misaligned),
    .rmw_count  (rmw_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  assign dmem_dout = mem[dmem_addr[9:2]];
  always @(posedge clk) if (dmem_write) mem[dmem_addr[9:2]] <= dmem_din;

  logic [7:0] ref_b [0:1023];

  int checks = 0;
  int errors = 0;
  int rmw_exp = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [31:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty got=%08h exp=none", got);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [9:0] w;
    w = {a[9:2], 2'b00};
    return {ref_b[w + 10'd3], ref_b[w + 10'd2], ref_b[w + 10'd1], ref_b[w]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [9:0]  hi;
    b  = ref_b[a[9:0]];
    hi = {a[9:1], 1'b0};
    h  = {ref_b[hi + 10'd1], ref_b[hi]};
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return ref_word(a);
    endcase
  endfunction

  task automatic idle_inputs();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'b000;
    addr       = 32'h0;
    store_data = 32'h0;
  endtask

  // Entered and left just after a posedge.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp);
    funct3    = f3;
    addr      = a;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    sb_push(tag, exp);
    @(negedge clk);
    check({tag, "_stall"}, {31'h0, stall}, 32'h0);
    sb_pop_check(load_data);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output int cycles);
    logic [9:0] base;
    logic       sub;
    logic       done;
    funct3     = f3;
    addr       = a;
    store_data = d;
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    sub        = (f3 == 3'b000) || (f3 == 3'b001);
    if (f3 == 3'b000) begin
      ref_b[a[9:0]] = d[7:0];
    end else if (f3 == 3'b001) begin
      base = {a[9:1], 1'b0};
      ref_b[base] = d[7:0];
      ref_b[base + 10'd1] = d[15:8];
    end else begin
      base = {a[9:2], 2'b00};
      for (int k = 0; k < 4; k++) ref_b[base + 10'(k)] = d[8*k +: 8];
    end
    if (sub) rmw_exp++;
    sb_push(tag, ref_word(a));
    cycles = 0;
    done   = 1'b0;
    while (!done && cycles < 4) begin
      @(negedge clk);
      cycles++;
      if (!stall) done = 1'b1;
      @(posedge clk);
      #1;
    end
    idle_inputs();
    check({tag, "_cycles"}, 32'(cycles), sub ? 32'd2 : 32'd1);
    sb_pop_check(mem[a[9:2]]);
  endtask

  int c1, c2;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 1024; i++) ref_b[i] = 8'h0;
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    @(negedge clk);
    check("rst_dmem_read", {31'h0, dmem_read}, 32'h0);
    check("rst_dmem_write", {31'h0, dmem_write}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_misaligned", {31'h0, misaligned}, 32'h0);
    check("rst_rmw_count", rmw_count, 32'h0);
    @(posedge clk);
    #1;

    do_store("sw_100", 3'b010, 32'h100, 32'h11223344, c1);
    do_load("lw_100", 3'b010, 32'h100, 32'h11223344);

    do_store("sb_101", 3'b000, 32'h101, 32'h000000AB, c1);
    check("sb_101_word", mem[8'h40], 32'h1122AB44);
    check("sb_101_rmw_count", rmw_count, 32'd1);

    funct3   = 3'b000;
    addr     = 32'h101;
    mem_read = 1'b1;
    #1;
    check("lb_dmem_addr", dmem_addr, 32'h100);
    idle_inputs();
    do_load("lb_101", 3'b000, 32'h101, 32'hFFFFFFAB);
    do_load("lbu_101", 3'b100, 32'h101, 32'h000000AB);
    do_load("lh_100", 3'b001, 32'h100, 32'hFFFFAB44);
    do_load("lhu_102", 3'b101, 32'h102, 32'h00001122);
    do_load("lb_100", 3'b000, 32'h100, 32'h00000044);

    do_store("sh_102", 3'b001, 32'h102, 32'h0000BEEF, c1);
    do_store("sb_100", 3'b000, 32'h100, 32'h00000001, c2);
    check("b2b_total_cycles", 32'(c1 + c2), 32'd4);
    check("b2b_word", mem[8'h40], 32'hBEEFAB01);
    check("b2b_rmw_count", rmw_count, 32'd3);
    do_load("lw_after_rmw", 3'b010, 32'h100, 32'hBEEFAB01);

    // Load and store asserted together: the load wins and nothing is written.
    funct3     = 3'b010;
    addr       = 32'h100;
    store_data = 32'hDEADDEAD;
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    sb_push("rw_both_load", 32'hBEEFAB01);
    @(negedge clk);
    check("rw_both_dmem_write", {31'h0, dmem_write}, 32'h0);
    sb_pop_check(load_data);
    @(posedge clk);
    #1;
    idle_inputs();
    check("rw_both_word", mem[8'h40], 32'hBEEFAB01);

    do_store("sw_104", 3'b010, 32'h104, 32'hCAFEF00D, c1);
    funct3     = 3'b000;
    addr       = 32'h104;
    store_data = 32'h00000055;
    mem_write  = 1'b1;
    @(negedge clk);
    check("abort_first_stall", {31'h0, stall}, 32'h1);
    @(posedge clk);
    #1;
    check("abort_in_rmw_wr", {31'h0, dmem_write}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_dmem_write", {31'h0, dmem_write}, 32'h0);
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
    rmw_exp = 0;
    check("abort_word", mem[8'h41], 32'hCAFEF00D);
    check("abort_rmw_count", rmw_count, 32'h0);
    @(negedge clk);
    check("abort_idle_write", {31'h0, dmem_write}, 32'h0);
    check("abort_idle_stall", {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1;
    do_load("abort_lw_104", 3'b010, 32'h104, 32'hCAFEF00D);

    funct3   = 3'b010;
    addr     = 32'h102;
    mem_read = 1'b1;
    @(negedge clk);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    check("mis_flag", {31'h0, misaligned}, 32'h1);
    check("mis_dmem_read", {31'h0, dmem_read}, 32'h0);
    check("mis_load_data", load_data, 32'h0);
`else
    check("mis_flag", {31'h0, misaligned}, 32'h0);
    check("mis_dmem_read", {31'h0, dmem_read}, 32'h1);
    check("mis_dmem_addr", dmem_addr, 32'h100);
    check("mis_load_data", load_data, 32'hBEEFAB01);
`endif
    @(posedge clk);
    #1;
    idle_inputs();

    // Aligned random mix against the byte-level reference memory.
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      int          sel;
      sel = $urandom_range(0, 4);
      case (sel)
        0:       f3 = 3'b000;
        1:       f3 = 3'b001;
        2:       f3 = 3'b010;
        3:       f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      a = 32'h200 + 32'($urandom_range(0, 15));
      if (f3 == 3'b001 || f3 == 3'b101) a[0] = 1'b0;
      if (f3 == 3'b010) a[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 1 && f3 <= 3'b010)
        do_store("rnd_store", f3, a, $urandom(), c1);
      else
        do_load("rnd_load", f3, a, ref_load(f3, a));
    end
    check("rnd_rmw_count", rmw_count, 32'(rmw_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit directly upstream of the word-only data memory (async read, sync write on posedge clk, word index = addr>>2).
- Converts LB/LH/LW/LBU/LHU/SB/SH/SW from the EX/MEM register into word accesses.
- Sub-word stores are done as a 2-cycle read-modify-write (RMW), and the unit stalls the pipeline for one cycle while it runs.
- Loads are extracted and sign- or zero-extended for MEM/WB.

Parameters:
- XLEN, 32, datapath and address width; only 32 is supported.
- CNT_W, 32, width of the RMW event counter.

Ports:
- clk  in  1  pipeline clock, all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- mem_read  in  1  EX/MEM: instruction is a load.
- mem_write  in  1  EX/MEM: instruction is a store.
- funct3  in  3  EX/MEM: access size and sign (RISC-V encoding).
- addr  in  XLEN  EX/MEM: byte address from the ALU.
- store_data  in  XLEN  EX/MEM: rs2 value, right-aligned.
- dmem_dout  in  XLEN  data memory read data.
- dmem_addr  out  XLEN  data memory address, word-aligned (low 2 bits = 0).
- dmem_din  out  XLEN  data memory write data.
- dmem_read  out  1  data memory read enable.
- dmem_write  out  1  data memory write enable.
- load_data  out  XLEN  extended load result to MEM/WB.
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; insert a bubble into MEM/WB.
- misaligned  out  1  misaligned access flag (only with the optional feature).
- rmw_count  out  CNT_W  number of completed RMW writes.

Behaviour:
- FSM has two states: IDLE and RMW_WR. Reset value is IDLE.
- Reset values: rmw_count=0, latched word/lane/size=0. All outputs are combinational from state and inputs, so in IDLE with no access every output is 0.
- IDLE, load: dmem_read=1, dmem_addr={addr[31:2],2'b00}. load_data comes from dmem_dout in the same cycle (0 extra latency).
  - LB/LBU select the byte addr[1:0].
  - LH/LHU select the halfword addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Any other funct3 is treated as LW.
- IDLE, SW (funct3=010 or unknown): dmem_write=1, dmem_din=store_data. Single cycle, no stall.
- IDLE, SB/SH:
  - dmem_read=1, stall=1.
  - On the posedge, latch dmem_dout, addr[1:0], funct3 and store_data, then go to RMW_WR.
- RMW_WR:
  - dmem_write=1, dmem_addr is the latched word address, stall=0.
  - dmem_din is the latched word with the target byte (SB, lane addr[1:0]) or halfword (SH, lane addr[1]) replaced by the low bits of store_data.
  - EX/MEM inputs are ignored in this state; the latched copies are used.
  - On the posedge: return to IDLE and increment rmw_count (wraps modulo 2^CNT_W).
- mem_read and mem_write both 1 is illegal. Priority goes to the load and no write is issued.
- Back-to-back sub-word stores: each costs exactly 2 cycles. The second store sees the first store's written data, because the memory write lands at the end of RMW_WR.
- Load immediately after an RMW: the write completed at the previous edge, so the load returns the merged value.
- Reset asserted in RMW_WR: return to IDLE immediately with dmem_write=0. No partial write occurs and rmw_count is unchanged (or 0 if cleared by reset).

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]!=0, asserts misaligned for that cycle.
  - dmem_read and dmem_write are forced to 0, no RMW is started, and load_data=0.
- Undefined:
  - misaligned is tied to 0.
  - Halfword lanes use addr[1] only and words ignore addr[1:0]; the access is silently aligned down.

Decomposition:
- Shared package mem_pkg:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - state typedef {IDLE, RMW_WR}.
  - localparams for lane selection.
- Sub-module byte_lane_merge: purely combinational; word + lane + size + data produces the merged word. It is reused in the load-extract path, mirrored.

Test Plan:
- SW 0x11223344 @0x100, then LW @0x100 -> no stall; load_data=0x11223344.
- SB 0xAB @0x101 -> stall=1 for exactly 1 cycle; mem[0x40]=0x1122AB44; rmw_count=1.
- LB @0x101 -> 0xFFFFFFAB. LBU @0x101 -> 0x000000AB. LH @0x100 -> 0xFFFFAB44.
- SH 0xBEEF @0x102, then SB 0x01 @0x100 back-to-back -> 4 cycles total; final word 0xBEEFAB01; rmw_count=3.
- Reset driven to 0 during RMW_WR of SB 0x55 @0x104 -> dmem_write stays 0, mem[0x41] unchanged, state=IDLE, rmw_count=0.
- With the macro defined, LW @0x102 -> misaligned=1, dmem_read=0, load_data=0. Without it -> reads word @0x100, misaligned=0.
